// File: rtl/rf_pkg.sv
// rf_pkg: shared types and helpers for param_reg_file
//   rf_state_t : clear-sequence FSM states
//   rf_depth() : register count for a given address width
package rf_pkg;
  typedef enum logic {RF_INIT, RF_RUN} rf_state_t;
  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction
endpackage

// File: rtl/param_reg_file_if.sv
// param_reg_file_if: read/write-back/reserve bus of the register file
//   rd_addr/rd_data/rd_pending : NUM_RD packed read ports
//   wr_en/wr_dst/wr_data       : write-back
//   rsv_en/rsv_dst             : reservation at issue
//   init_busy                  : clear sequence running
interface param_reg_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_dst;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_dst;
  logic                     init_busy;
  modport master (output rd_addr, wr_en, wr_dst, wr_data, rsv_en, rsv_dst,
                  input rd_data, rd_pending, init_busy);
  modport slave (input rd_addr, wr_en, wr_dst, wr_data, rsv_en, rsv_dst,
                 output rd_data, rd_pending, init_busy);
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits with NUM_RD post-update lookups
//   i_set/i_set_dst : reserve (wins over clear on the same register)
//   i_clr/i_clr_dst : write-back clear
//   i_look_addr     : packed lookup addresses
//   o_look_nxt      : pending value of each looked-up register after this edge
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_set,
  input  logic [ADDR_W-1:0]        i_set_dst,
  input  logic                     i_clr,
  input  logic [ADDR_W-1:0]        i_clr_dst,
  input  logic [NUM_RD*ADDR_W-1:0] i_look_addr,
  output logic [NUM_RD-1:0]        o_look_nxt
);
  localparam int DEPTH = rf_depth(ADDR_W);
  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_nxt;
  for (genvar j = 0; j < DEPTH; j++) begin : g_bit
    assign w_nxt[j] = (i_set && i_set_dst == ADDR_W'(j)) |
                      (r_pend[j] & ~(i_clr && i_clr_dst == ADDR_W'(j)));
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_look
    assign o_look_nxt[i] = w_nxt[i_look_addr[i*ADDR_W +: ADDR_W]];
  end
  always_ff @(posedge clk)
    r_pend <= rst ? '0 : w_nxt;
endmodule

// File: rtl/param_reg_file.sv
// param_reg_file: multi-read-port register file with write-first bypass,
//   pending scoreboard and post-reset clear sequence
//   clk, rst : clock, synchronous active-high reset
//   rf       : slave side of param_reg_file_if
module param_reg_file
  import rf_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int NUM_RD  = 2,
  parameter bit R0_ZERO = 0,
  parameter bit BYPASS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  param_reg_file_if.slave  rf
);
  localparam int DEPTH = rf_depth(ADDR_W);
  rf_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [NUM_RD*DATA_W-1:0] r_rd_data;
  logic [NUM_RD-1:0] r_rd_pending;
  logic [NUM_RD-1:0] w_look;
  logic [DATA_W-1:0] w_rd_nxt [NUM_RD];
  logic w_run, w_we, w_rsv;
  assign w_run = r_state == RF_RUN && !rst;
  assign w_we  = w_run && rf.wr_en && !(R0_ZERO && rf.wr_dst == '0);
  assign w_rsv = w_run && rf.rsv_en && !(R0_ZERO && rf.rsv_dst == '0);
  always_comb
    w_state_nxt = (r_state == RF_INIT && r_clr_cnt == ADDR_W'(DEPTH - 1)) ? RF_RUN : r_state;
  always_ff @(posedge clk) begin
    r_state   <= rst ? RF_INIT : w_state_nxt;
    r_clr_cnt <= (rst || r_state != RF_INIT) ? '0 : r_clr_cnt + 1'b1;
  end
  always_ff @(posedge clk)
    if (r_state == RF_INIT) r_mem[r_clr_cnt] <= '0;
    else if (w_we) r_mem[rf.wr_dst] <= rf.wr_data;
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = rf.rd_addr[i*ADDR_W +: ADDR_W];
    // w_we already excludes r0 when R0_ZERO, so bypass never hits address 0 there
    assign w_rd_nxt[i] = (R0_ZERO && w_addr == '0) ? '0 :
                         (BYPASS && w_we && rf.wr_dst == w_addr) ? rf.wr_data : r_mem[w_addr];
  end
  rf_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set      (w_rsv),
    .i_set_dst  (rf.rsv_dst),
    .i_clr      (w_we),
    .i_clr_dst  (rf.wr_dst),
    .i_look_addr(rf.rd_addr),
    .o_look_nxt (w_look)
  );
  always_ff @(posedge clk)
    if (!w_run) begin
      r_rd_data    <= '0;
      r_rd_pending <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) r_rd_data[i*DATA_W +: DATA_W] <= w_rd_nxt[i];
      r_rd_pending <= w_look;
    end
  assign rf.rd_data    = r_rd_data;
  assign rf.rd_pending = r_rd_pending;
  assign rf.init_busy  = r_state == RF_INIT;
endmodule

// File: tb/tb_param_reg_file.sv
// tb_param_reg_file: directed checks of default, BYPASS=0 and R0_ZERO/NUM_RD=3 builds
module tb_param_reg_file;
  logic clk = 0;
  logic rst = 0;
  logic wr_en = 0, rsv_en = 0;
  logic [3:0] wr_dst = 0, rsv_dst = 0;
  logic [15:0] wr_data = 0;
  logic [7:0] rd_addr = 0;
  logic [11:0] rd3 = 0;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  param_reg_file_if #(.NUM_RD(2)) ia ();
  param_reg_file_if #(.NUM_RD(2)) ib ();
  param_reg_file_if #(.NUM_RD(3)) ic ();
  assign ia.wr_en = wr_en;   assign ib.wr_en = wr_en;   assign ic.wr_en = wr_en;
  assign ia.wr_dst = wr_dst; assign ib.wr_dst = wr_dst; assign ic.wr_dst = wr_dst;
  assign ia.wr_data = wr_data; assign ib.wr_data = wr_data; assign ic.wr_data = wr_data;
  assign ia.rsv_en = rsv_en; assign ib.rsv_en = rsv_en; assign ic.rsv_en = rsv_en;
  assign ia.rsv_dst = rsv_dst; assign ib.rsv_dst = rsv_dst; assign ic.rsv_dst = rsv_dst;
  assign ia.rd_addr = rd_addr; assign ib.rd_addr = rd_addr; assign ic.rd_addr = rd3;
  param_reg_file u_a (.clk(clk), .rst(rst), .rf(ia));
  param_reg_file #(.BYPASS(0)) u_b (.clk(clk), .rst(rst), .rf(ib));
  param_reg_file #(.NUM_RD(3), .R0_ZERO(1)) u_c (.clk(clk), .rst(rst), .rf(ic));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [3:0] d, input logic [15:0] v);
    wr_en = 1; wr_dst = d; wr_data = v;
  endtask
  task automatic count_busy(input string tag);
    int cnt = 0;
    while (ia.init_busy && cnt < 40) begin
      cnt++;
      tick();
    end
    check(tag, 64'(cnt), 64'd16);
  endtask
  initial begin
    rst = 1; tick(); rst = 0;
    check("init_rd_zero", {ia.rd_pending, ia.rd_data}, 0);
    check("init_busy_c", 64'(ic.init_busy), 1);
    count_busy("init_len");
    check("busy_b_done", 64'(ib.init_busy), 0);
    for (int k = 0; k < 16; k++) begin
      rd_addr = {4'(15 - k), 4'(k)};
      tick();
      check("clr_a", {ia.rd_pending, ia.rd_data}, 0);
      check("clr_b", {ib.rd_pending, ib.rd_data}, 0);
    end
    wr(5, 16'hBEEF); tick(); wr_en = 0;
    rd_addr = 8'h05; tick();
    check("wr5_a", 64'(ia.rd_data[15:0]), 64'hBEEF);
    check("wr5_b", 64'(ib.rd_data[15:0]), 64'hBEEF);
    wr(0, 16'h0F0F); rd_addr = 8'h00; tick(); wr_en = 0; tick();
    check("wr0_a", 64'(ia.rd_data[15:0]), 64'h0F0F);
    wr(3, 16'h1234); rd_addr = 8'h35; tick(); wr_en = 0;
    check("byp_a", ia.rd_data, 64'h1234BEEF);
    check("nobyp_b", ib.rd_data, 64'h0000BEEF);
    tick();
    check("old_b", ib.rd_data, 64'h1234BEEF);
    rsv_en = 1; rsv_dst = 7; rd_addr = 8'h37; tick(); rsv_en = 0;
    check("rsv7", 64'(ia.rd_pending), 64'b01);
    wr(7, 16'h00AA); tick(); wr_en = 0;
    check("wr7_pend", 64'(ia.rd_pending), 0);
    check("wr7_data", ia.rd_data, 64'h123400AA);
    wr(7, 16'h00AA); rsv_en = 1; rsv_dst = 7; rd_addr = 8'h73; tick();
    wr_en = 0; rsv_en = 0;
    check("rsvwr_pend", 64'(ia.rd_pending), 64'b10);
    tick();
    check("rsvwr_hold", {ia.rd_pending, ia.rd_data}, {2'b10, 32'h00AA1234});
    wr(2, 16'h2222); tick(); wr_en = 0;
    rsv_en = 1; rsv_dst = 2; rd_addr = 8'h42; tick(); rsv_en = 0;
    check("r2_pend", {ia.rd_pending, ia.rd_data}, {2'b01, 32'h00002222});
    rst = 1; tick(); rst = 0;
    for (int k = 0; k < 7; k++) tick();
    check("mid_init_busy", 64'(ia.init_busy), 1);
    rst = 1; tick(); rst = 0;
    wr(2, 16'h5555); rsv_en = 1; rsv_dst = 4;
    count_busy("reinit_len");
    wr_en = 0; rsv_en = 0;
    tick();
    check("r2_clear", {ia.rd_pending, ia.rd_data}, 0);
    check("r2_clear_b", {ib.rd_pending, ib.rd_data}, 0);
    tick();
    rd_addr = 8'h57;
    tick();
    check("r5r7_clear", {ia.rd_pending, ia.rd_data}, 0);
    wr(0, 16'hFFFF); rsv_en = 1; rsv_dst = 0; rd3 = 12'h000; tick();
    wr_en = 0; rsv_en = 0;
    check("r0_c_byp", {ic.rd_pending, ic.rd_data}, 0);
    tick();
    check("r0_c_hold", {ic.rd_pending, ic.rd_data}, 0);
    wr(1, 16'h1111); rsv_en = 1; rsv_dst = 1; rd3 = 12'h110; tick();
    wr_en = 0; rsv_en = 0;
    check("r1_c", {ic.rd_pending, ic.rd_data}, {3'b110, 48'h111111110000});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
